// File: rtl/mexec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mexec_pkg: shared state encoding, FPU opcodes and defaults for           |
// | the multi-cycle execute controller.  Revision: 1.0                      |
// +--------------------------------------------------------------------------+
package mexec_pkg;

   localparam logic [1:0] C_ST_IDLE     = 2'd0;
   localparam logic [1:0] C_ST_FPU_BUSY = 2'd1;
   localparam logic [1:0] C_ST_MM_BUSY  = 2'd2;
   localparam logic [1:0] C_ST_DONE     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = C_ST_IDLE,
      ST_FPU_BUSY = C_ST_FPU_BUSY,
      ST_MM_BUSY  = C_ST_MM_BUSY,
      ST_DONE     = C_ST_DONE
   } mexec_state_e;

   localparam logic [2:0] C_FPU_OP_ADD  = 3'b000;
   localparam logic [2:0] C_FPU_OP_SUB  = 3'b001;
   localparam logic [2:0] C_FPU_OP_MUL  = 3'b010;
   localparam logic [2:0] C_FPU_OP_DIV  = 3'b011;
   localparam logic [2:0] C_FPU_OP_SQRT = 3'b100;

   localparam int C_TIMEOUT_DEFAULT = 64;
   localparam int C_XLEN_DEFAULT    = 32;

endpackage
`default_nettype wire

// File: rtl/mexec_wait_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mexec_wait_ctr: busy-cycle counter with clear/increment and expiry flag. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mexec_wait_ctr
   import mexec_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = C_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam int             C_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [C_W-1:0] C_LAST = C_W'(TIMEOUT_CYCLES - 1);

   logic [C_W-1:0] cnt_q;
   logic [C_W-1:0] cnt_d;

   // Holds at the last value so an ignored expiry can never wrap to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != C_LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_exec_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_exec_ctrl: launches FPU/matmul from Execute and stalls F/D/E  |
// | until done. Optional perf counters: define MEXEC_PERF_EN. Revision: 1.0  |
// +--------------------------------------------------------------------------+
module multicycle_exec_ctrl
   import mexec_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = C_TIMEOUT_DEFAULT,
   parameter int XLEN           = C_XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            FPUStartE,
   input  logic [2:0]      FPUControlE,
   input  logic            MatmulStartE,
   input  logic            fpu_done,
   input  logic [XLEN-1:0] fpu_result,
   input  logic            mm_done,
   output logic            fpu_go,
   output logic [2:0]      fpu_op,
   output logic            mm_go,
   output logic            StallF,
   output logic            StallD,
   output logic            StallE,
   output logic            FlushM,
   output logic            ResultValidE,
   output logic [XLEN-1:0] ResultE,
   output logic            err_timeout
`ifdef MEXEC_PERF_EN
   ,
   output logic [31:0]     perf_fpu_cyc,
   output logic [31:0]     perf_mm_cyc
`endif
);

   mexec_state_e    state_q, state_d;
   logic            mm_pend_q, mm_pend_d;
   logic [2:0]      fpu_op_q, fpu_op_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            fpu_go_q, fpu_go_d;
   logic            mm_go_q, mm_go_d;
   logic            err_q, err_d;
   logic            stall;
   logic            ctr_clr;
   logic            ctr_inc;
   logic            ctr_expire;
   logic            start;

   assign start = FPUStartE | MatmulStartE;

   mexec_wait_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_ctr (
      .clk    (clk),
      .reset  (reset),
      .clr    (ctr_clr),
      .inc    (ctr_inc),
      .expire (ctr_expire)
   );

   always_comb begin
      state_d   = state_q;
      mm_pend_d = mm_pend_q;
      fpu_op_d  = fpu_op_q;
      res_d     = res_q;
      err_d     = err_q;
      stall     = 1'b0;
      ctr_clr   = 1'b0;
      ctr_inc   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               stall     = 1'b1;
               state_d   = FPUStartE ? ST_FPU_BUSY : ST_MM_BUSY;
               mm_pend_d = FPUStartE & MatmulStartE;
               fpu_op_d  = FPUControlE;
               res_d     = '0;
               ctr_clr   = 1'b1;
            end
         end
         ST_FPU_BUSY: begin
            stall   = 1'b1;
            ctr_inc = 1'b1;
            // A done strobe wins over an expiry in the same cycle.
            if (fpu_done) begin
               res_d = fpu_result;
               if (mm_pend_q) begin
                  mm_pend_d = 1'b0;
                  state_d   = ST_MM_BUSY;
                  ctr_clr   = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (ctr_expire) begin
               err_d     = 1'b1;
               res_d     = '0;
               mm_pend_d = 1'b0;
               state_d   = ST_DONE;
            end
         end
         ST_MM_BUSY: begin
            stall   = 1'b1;
            ctr_inc = 1'b1;
            if (mm_done) begin
               state_d = ST_DONE;
            end else if (ctr_expire) begin
               err_d     = 1'b1;
               res_d     = '0;
               mm_pend_d = 1'b0;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      fpu_go_d = (state_d == ST_FPU_BUSY) && (state_q != ST_FPU_BUSY);
      mm_go_d  = (state_d == ST_MM_BUSY) && (state_q != ST_MM_BUSY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         mm_pend_q <= 1'b0;
         fpu_op_q  <= '0;
         res_q     <= '0;
         fpu_go_q  <= 1'b0;
         mm_go_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mm_pend_q <= mm_pend_d;
         fpu_op_q  <= fpu_op_d;
         res_q     <= res_d;
         fpu_go_q  <= fpu_go_d;
         mm_go_q   <= mm_go_d;
         err_q     <= err_d;
      end
   end

   assign fpu_go       = fpu_go_q;
   assign mm_go        = mm_go_q;
   assign fpu_op       = fpu_op_q;
   assign StallF       = stall;
   assign StallD       = stall;
   assign StallE       = stall;
   assign FlushM       = stall;
   assign ResultValidE = (state_q == ST_DONE);
   assign ResultE      = (state_q == ST_DONE) ? res_q : '0;
   assign err_timeout  = err_q;

`ifdef MEXEC_PERF_EN
   logic [31:0] perf_fpu_q, perf_fpu_d;
   logic [31:0] perf_mm_q, perf_mm_d;

   always_comb begin
      perf_fpu_d = perf_fpu_q;
      perf_mm_d  = perf_mm_q;
      if ((state_q == ST_FPU_BUSY) && (perf_fpu_q != '1)) begin
         perf_fpu_d = perf_fpu_q + 32'd1;
      end
      if ((state_q == ST_MM_BUSY) && (perf_mm_q != '1)) begin
         perf_mm_d = perf_mm_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fpu_q <= '0;
         perf_mm_q  <= '0;
      end else begin
         perf_fpu_q <= perf_fpu_d;
         perf_mm_q  <= perf_mm_d;
      end
   end

   assign perf_fpu_cyc = perf_fpu_q;
   assign perf_mm_cyc  = perf_mm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_exec_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_exec_ctrl: directed vector bench for multicycle_exec_ctrl. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_exec_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        FPUStartE;
   logic [2:0]  FPUControlE;
   logic        MatmulStartE;
   logic        fpu_done;
   logic [31:0] fpu_result;
   logic        mm_done;
   logic        fpu_go;
   logic [2:0]  fpu_op;
   logic        mm_go;
   logic        StallF, StallD, StallE, FlushM;
   logic        ResultValidE;
   logic [31:0] ResultE;
   logic        err_timeout;
`ifdef MEXEC_PERF_EN
   logic [31:0] perf_fpu_cyc, perf_mm_cyc;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multicycle_exec_ctrl #(.TIMEOUT_CYCLES(64), .XLEN(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .FPUStartE    (FPUStartE),
      .FPUControlE  (FPUControlE),
      .MatmulStartE (MatmulStartE),
      .fpu_done     (fpu_done),
      .fpu_result   (fpu_result),
      .mm_done      (mm_done),
      .fpu_go       (fpu_go),
      .fpu_op       (fpu_op),
      .mm_go        (mm_go),
      .StallF       (StallF),
      .StallD       (StallD),
      .StallE       (StallE),
      .FlushM       (FlushM),
      .ResultValidE (ResultValidE),
      .ResultE      (ResultE),
      .err_timeout  (err_timeout)
`ifdef MEXEC_PERF_EN
      ,
      .perf_fpu_cyc (perf_fpu_cyc),
      .perf_mm_cyc  (perf_mm_cyc)
`endif
   );

   typedef struct {
      logic        fs;
      logic        ms;
      logic [2:0]  op;
      logic        fd;
      logic [31:0] fr;
      logic        md;
      logic        e_fgo;
      logic        e_mgo;
      logic        e_stall;
      logic        e_rv;
      logic [31:0] e_res;
      logic [2:0]  e_op;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic fs, input logic ms, input logic [2:0] op,
                               input logic fd, input logic [31:0] fr, input logic md,
                               input logic e_fgo, input logic e_mgo, input logic e_stall,
                               input logic e_rv, input logic [31:0] e_res,
                               input logic [2:0] e_op);
      vec_t v;
      v.fs = fs; v.ms = ms; v.op = op; v.fd = fd; v.fr = fr; v.md = md;
      v.e_fgo = e_fgo; v.e_mgo = e_mgo; v.e_stall = e_stall; v.e_rv = e_rv;
      v.e_res = e_res; v.e_op = e_op;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fs, input logic ms, input logic [2:0] op,
                        input logic fd, input logic [31:0] fr, input logic md);
      FPUStartE = fs; MatmulStartE = ms; FPUControlE = op;
      fpu_done = fd; fpu_result = fr; mm_done = md;
   endtask

   initial begin
      int n_stall, n_mgo, n_fgo, n_rv;
      logic rv_seen;
      logic [31:0] res_seen;
      logic err_seen;

      reset = 1'b1;
      drive(0, 0, 3'd0, 0, 32'd0, 0);

      // Cycle-by-cycle vectors: FPU-only, FPU+matmul, zero-wait FPU.
      tbl.push_back(mk(0,0,3'd0,0,32'h0,0,        0,0,0,0,32'h0,3'd0));
      tbl.push_back(mk(1,0,3'd2,0,32'h0,0,        0,0,1,0,32'h0,3'd0));
      tbl.push_back(mk(1,0,3'd2,0,32'h0,0,        1,0,1,0,32'h0,3'd2));
      tbl.push_back(mk(1,0,3'd2,0,32'h0,1,        0,0,1,0,32'h0,3'd2));
      tbl.push_back(mk(1,0,3'd2,0,32'h0,0,        0,0,1,0,32'h0,3'd2));
      tbl.push_back(mk(1,0,3'd2,1,32'h3F800000,0, 0,0,1,0,32'h0,3'd2));
      tbl.push_back(mk(1,0,3'd2,0,32'h0,0,        0,0,0,1,32'h3F800000,3'd2));
      tbl.push_back(mk(0,0,3'd0,1,32'hDEADBEEF,0, 0,0,0,0,32'h0,3'd2));
      tbl.push_back(mk(0,0,3'd0,0,32'h0,0,        0,0,0,0,32'h0,3'd2));
      tbl.push_back(mk(1,1,3'd1,0,32'h0,0,        0,0,1,0,32'h0,3'd2));
      tbl.push_back(mk(1,1,3'd1,0,32'h0,0,        1,0,1,0,32'h0,3'd1));
      tbl.push_back(mk(1,1,3'd1,1,32'h40000000,0, 0,0,1,0,32'h0,3'd1));
      tbl.push_back(mk(1,1,3'd1,0,32'h0,0,        0,1,1,0,32'h0,3'd1));
      tbl.push_back(mk(1,1,3'd1,0,32'h0,1,        0,0,1,0,32'h0,3'd1));
      tbl.push_back(mk(1,1,3'd1,0,32'h0,0,        0,0,0,1,32'h40000000,3'd1));
      tbl.push_back(mk(0,0,3'd0,0,32'h0,0,        0,0,0,0,32'h0,3'd1));
      tbl.push_back(mk(1,0,3'd4,0,32'h0,0,        0,0,1,0,32'h0,3'd1));
      tbl.push_back(mk(1,0,3'd4,1,32'h12345678,0, 1,0,1,0,32'h0,3'd4));
      tbl.push_back(mk(1,0,3'd4,0,32'h0,0,        0,0,0,1,32'h12345678,3'd4));
      tbl.push_back(mk(0,0,3'd0,0,32'h0,0,        0,0,0,0,32'h0,3'd4));
      tbl.push_back(mk(0,0,3'd0,0,32'h0,0,        0,0,0,0,32'h0,3'd4));

      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_fpu_go", {31'd0, fpu_go}, 32'd0);
      chk("rst_mm_go", {31'd0, mm_go}, 32'd0);
      chk("rst_stall", {28'd0, StallF, StallD, StallE, FlushM}, 32'd0);
      chk("rst_valid", {31'd0, ResultValidE}, 32'd0);
      chk("rst_result", ResultE, 32'd0);
      chk("rst_fpu_op", {29'd0, fpu_op}, 32'd0);
      chk("rst_err", {31'd0, err_timeout}, 32'd0);
      next_cycle();
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].fs, tbl[i].ms, tbl[i].op, tbl[i].fd, tbl[i].fr, tbl[i].md);
         @(negedge clk);
         chk($sformatf("v%0d_fpu_go", i), {31'd0, fpu_go}, {31'd0, tbl[i].e_fgo});
         chk($sformatf("v%0d_mm_go", i), {31'd0, mm_go}, {31'd0, tbl[i].e_mgo});
         chk($sformatf("v%0d_stall", i), {28'd0, StallF, StallD, StallE, FlushM},
             {28'd0, {4{tbl[i].e_stall}}});
         chk($sformatf("v%0d_valid", i), {31'd0, ResultValidE}, {31'd0, tbl[i].e_rv});
         chk($sformatf("v%0d_result", i), ResultE, tbl[i].e_res);
         chk($sformatf("v%0d_fpu_op", i), {29'd0, fpu_op}, {29'd0, tbl[i].e_op});
         chk($sformatf("v%0d_err", i), {31'd0, err_timeout}, 32'd0);
         next_cycle();
      end

      // Matmul only: done in the 10th busy cycle.
      n_stall = 0; n_mgo = 0; n_fgo = 0; n_rv = 0;
      for (int c = 0; c < 14; c++) begin
         drive(0, (c <= 11), 3'd0, 0, 32'h0, (c == 10));
         @(negedge clk);
         if (StallE) n_stall++;
         if (mm_go) n_mgo++;
         if (fpu_go) n_fgo++;
         if (ResultValidE) begin
            n_rv++;
            chk("mm_result", ResultE, 32'd0);
            chk("mm_valid_cycle", c, 32'd11);
         end
         next_cycle();
      end
      chk("mm_stall_cycles", n_stall, 32'd11);
      chk("mm_go_pulses", n_mgo, 32'd1);
      chk("mm_fpu_go_pulses", n_fgo, 32'd0);
      chk("mm_valid_pulses", n_rv, 32'd1);

      // FPU that never finishes: forced abort after 64 busy cycles.
      n_stall = 0; rv_seen = 1'b0; res_seen = 32'hFFFF_FFFF; err_seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         drive(1, 0, 3'd3, 0, 32'h0, 0);
         @(negedge clk);
         if (c == 1) chk("to_err_early", {31'd0, err_timeout}, 32'd0);
         if (ResultValidE) begin
            rv_seen = 1'b1;
            res_seen = ResultE;
            err_seen = err_timeout;
            next_cycle();
            break;
         end
         if (StallE) n_stall++;
         next_cycle();
      end
      chk("to_done_seen", {31'd0, rv_seen}, 32'd1);
      chk("to_stall_cycles", n_stall, 32'd65);
      chk("to_result", res_seen, 32'd0);
      chk("to_err_at_done", {31'd0, err_seen}, 32'd1);
      drive(0, 0, 3'd0, 0, 32'h0, 0);
      @(negedge clk);
      chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
      chk("to_idle_stall", {31'd0, StallE}, 32'd0);
      next_cycle();

      // Reset while the FPU is busy, then a stray done afterwards.
      drive(1, 0, 3'd5, 0, 32'h0, 0);
      next_cycle();
      @(negedge clk);
      chk("rs_go", {31'd0, fpu_go}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("rs_busy_stall", {31'd0, StallE}, 32'd1);
      #1;
      reset = 1'b1;
      drive(0, 0, 3'd0, 0, 32'h0, 0);
      #1;
      chk("rs_stall_drop", {28'd0, StallF, StallD, StallE, FlushM}, 32'd0);
      chk("rs_err_clear", {31'd0, err_timeout}, 32'd0);
      chk("rs_fpu_op", {29'd0, fpu_op}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("rs_fpu_go", {31'd0, fpu_go}, 32'd0);
      next_cycle();
      reset = 1'b0;
      drive(0, 0, 3'd0, 1, 32'hCAFEF00D, 0);
      @(negedge clk);
      chk("rs_stray_stall", {31'd0, StallE}, 32'd0);
      next_cycle();
      drive(0, 0, 3'd0, 0, 32'h0, 0);
      @(negedge clk);
      chk("rs_stray_valid", {31'd0, ResultValidE}, 32'd0);
      chk("rs_stray_stall2", {31'd0, StallE}, 32'd0);
      chk("rs_stray_go", {31'd0, fpu_go}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
